// File: rtl/trigger_qualifier.sv
// Trigger conditioning for the glitch generator: sync, debounce, edge select, Nth-edge fire, holdoff.
// Optional TRIG_QUAL_REARM_EN: holdoff re-arms with the previously latched N instead of idling.
module trigger_qualifier #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_in,
  input  logic             edge_sel,
  input  logic             arm,
  input  logic             abort,
  input  logic [CNT_W-1:0] nth_edge,
  input  logic             done,
  output logic             trigger,
  output logic             armed,
  output logic             busy,
  output logic             trig_filt,
  output logic [CNT_W-1:0] edge_count
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HO_W-1:0] HO_LAST = (HOLDOFF_CYCLES > 0) ? HO_W'(HOLDOFF_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_FIRE, S_WAIT_DONE, S_HOLDOFF
  } state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               trig_sync;
  logic [DB_W-1:0]    db_cnt;
  logic               filt_d;
  logic               edge_p;
  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   cnt_inc;
  logic [HO_W-1:0]    hold_cnt;

  assign trig_sync = sync_q[SYNC_STAGES-1];
  assign cnt_inc   = edge_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
  end

  // Commit after DEBOUNCE_CYCLES+1 disagreeing samples, placing the trig_filt change
  // SYNC_STAGES+DEBOUNCE_CYCLES edges after trig_in is first captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      trig_filt <= 1'b0;
      filt_d    <= 1'b0;
      edge_p    <= 1'b0;
    end else begin
      filt_d <= trig_filt;
      edge_p <= edge_sel ? (filt_d & ~trig_filt) : (~filt_d & trig_filt);
      if (trig_sync == trig_filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        trig_filt <= trig_sync;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      trigger    <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      edge_count <= '0;
      n_lat      <= CNT_W'(1);
      hold_cnt   <= '0;
    end else if (abort) begin
      state   <= S_IDLE;
      trigger <= 1'b0;
      armed   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm) begin
            state      <= S_ARMED;
            armed      <= 1'b1;
            edge_count <= '0;
            n_lat      <= (nth_edge == '0) ? CNT_W'(1) : nth_edge;
          end
        end
        S_ARMED: begin
          if (edge_p) begin
            edge_count <= cnt_inc;
            if (cnt_inc == n_lat) begin
              state   <= S_FIRE;
              trigger <= 1'b1;
              armed   <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          // A done level left over from the previous shot must drop before it can count.
          if (!done) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done) begin
            state    <= S_HOLDOFF;
            trigger  <= 1'b0;
            hold_cnt <= '0;
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt == HO_LAST) begin
            busy <= 1'b0;
`ifdef TRIG_QUAL_REARM_EN
            state      <= S_ARMED;
            armed      <= 1'b1;
            edge_count <= '0;
`else
            state <= S_IDLE;
`endif
          end else begin
            hold_cnt <= hold_cnt + HO_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
